// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: one requester's access port onto the shared single-port RAM.
// The requester drives req/we/addr/wdata/wmask; the arbiter returns gnt/rvalid/rdata.
interface ram_port_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic              req;
  logic              we;
  logic [AW-1:0]     addr;
  logic [DW-1:0]     wdata;
  logic [DW/8-1:0]   wmask;
  logic              gnt;
  logic              rvalid;
  logic [DW-1:0]     rdata;

  modport master (output req, we, addr, wdata, wmask, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, wmask, output gnt, rvalid, rdata);
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port RAM between the core (c) and PIM (p) requesters.
// Optional RAM_ARB_RR_EN selects round-robin tie-breaking; otherwise the core wins every tie.
module ram_port_arbiter #(
  parameter int AW     = 10,
  parameter int DW     = 32,
  parameter int RD_LAT = 2
) (
  input  logic                clk,
  input  logic                reset,
  ram_port_arbiter_if.slave   c,
  ram_port_arbiter_if.slave   p,
  output logic [AW-1:0]       ram_addr,
  output logic [DW-1:0]       ram_wdata,
  output logic [DW/8-1:0]     ram_byteena,
  output logic                ram_wen,
  output logic                ram_rden,
  input  logic [DW-1:0]       ram_rdata
);
  localparam int         BW       = DW / 8;
  localparam logic       ID_C     = 1'b0;
  localparam logic       ID_P     = 1'b1;
  localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);
`ifdef RAM_ARB_RR_EN
  localparam bit         RR_EN    = 1'b1;
`else
  localparam bit         RR_EN    = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  state_t          state_r;
  logic [2:0]      cnt_r;
  logic            we_r;
  logic            id_r;
  logic            last_r;
  logic            c_gnt_r;
  logic            p_gnt_r;
  logic            c_rvalid_r;
  logic            p_rvalid_r;

  logic            pick_p_s;
  logic            sel_we_s;
  logic [AW-1:0]   sel_addr_s;
  logic [DW-1:0]   sel_wdata_s;
  logic [BW-1:0]   sel_wmask_s;

  // Winner selection and request mux; only consulted while idle.
  always_comb begin
    pick_p_s = 1'b0;
    if (c.req && p.req) begin
      pick_p_s = RR_EN && (last_r == ID_C);
    end else if (p.req) begin
      pick_p_s = 1'b1;
    end else begin
      pick_p_s = 1'b0;
    end
    if (pick_p_s) begin
      sel_we_s    = p.we;
      sel_addr_s  = p.addr;
      sel_wdata_s = p.wdata;
      sel_wmask_s = p.wmask;
    end else begin
      sel_we_s    = c.we;
      sel_addr_s  = c.addr;
      sel_wdata_s = c.wdata;
      sel_wmask_s = c.wmask;
    end
  end

  // Access FSM: strobes, grants and read-valid are all registered pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= 3'd0;
      we_r        <= 1'b0;
      id_r        <= ID_C;
      last_r      <= ID_P;
      c_gnt_r     <= 1'b0;
      p_gnt_r     <= 1'b0;
      c_rvalid_r  <= 1'b0;
      p_rvalid_r  <= 1'b0;
      ram_addr    <= {AW{1'b0}};
      ram_wdata   <= {DW{1'b0}};
      ram_byteena <= {BW{1'b0}};
      ram_wen     <= 1'b0;
      ram_rden    <= 1'b0;
    end else begin
      c_gnt_r    <= 1'b0;
      p_gnt_r    <= 1'b0;
      c_rvalid_r <= 1'b0;
      p_rvalid_r <= 1'b0;
      ram_wen    <= 1'b0;
      ram_rden   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (c.req || p.req) begin
            id_r        <= pick_p_s;
            we_r        <= sel_we_s;
            ram_addr    <= sel_addr_s;
            ram_wdata   <= sel_wdata_s;
            ram_byteena <= sel_we_s ? sel_wmask_s : {BW{1'b1}};
            ram_wen     <= sel_we_s;
            ram_rden    <= ~sel_we_s;
            c_gnt_r     <= ~pick_p_s;
            p_gnt_r     <= pick_p_s;
            state_r     <= ISSUE;
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          last_r <= id_r;
          if (we_r) begin
            state_r <= IDLE;
          end else begin
            // With RD_LAT=1 the data is due in the very next cycle.
            cnt_r      <= CNT_INIT;
            c_rvalid_r <= (CNT_INIT == 3'd0) && (id_r == ID_C);
            p_rvalid_r <= (CNT_INIT == 3'd0) && (id_r == ID_P);
            state_r    <= RDWAIT;
          end
        end
        RDWAIT: begin
          if (cnt_r == 3'd0) begin
            state_r <= IDLE;
          end else begin
            cnt_r      <= cnt_r - 3'd1;
            c_rvalid_r <= (cnt_r == 3'd1) && (id_r == ID_C);
            p_rvalid_r <= (cnt_r == 3'd1) && (id_r == ID_P);
            state_r    <= RDWAIT;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign c.gnt    = c_gnt_r;
  assign p.gnt    = p_gnt_r;
  assign c.rvalid = c_rvalid_r;
  assign p.rvalid = p_rvalid_r;
  assign c.rdata  = ram_rdata;
  assign p.rdata  = ram_rdata;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: scoreboard bench with a queue-merge arbitration model and a RAM model.
module tb_ram_port_arbiter;
  localparam int AW     = 10;
  localparam int DW     = 32;
  localparam int RD_LAT = 2;

  typedef struct packed {
    logic          id;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    mask;
    logic [DW-1:0] rdata;
  } xact_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [3:0]    ram_byteena;
  logic          ram_wen;
  logic          ram_rden;
  logic [DW-1:0] ram_rdata;

  ram_port_arbiter_if #(.AW(AW), .DW(DW)) c_if ();
  ram_port_arbiter_if #(.AW(AW), .DW(DW)) p_if ();

  ram_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset), .c(c_if), .p(p_if),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_byteena(ram_byteena),
    .ram_wen(ram_wen), .ram_rden(ram_rden), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  int            vectors = 0;
  int            miscompares = 0;
  xact_t         exp_q[$];
  xact_t         cq[$];
  xact_t         pq[$];
  logic [DW-1:0] ram_mem [0:1023];
  logic [DW-1:0] ref_mem [0:1023];
  logic          model_ptr;
  logic          first_win;
  bit            pend_valid;
  int            pend_cnt;
  logic          pend_id;
  logic [DW-1:0] pend_data;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, want);
    end
  endtask

  task automatic fail_event(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s at time %0t", nm, $time);
  endtask

  function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] d,
                                              input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic xact_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input logic [3:0] m);
    xact_t t;
    t = '0;
    t.we = we; t.addr = a; t.wdata = d; t.mask = m;
    return t;
  endfunction

  // Monitor + scoreboard + RAM model, all evaluated away from the active edge.
  initial begin : monitor
    xact_t       e;
    int          rd_left;
    logic [31:0] rd_data;
    rd_left = 0; rd_data = '0; ram_rdata = '0;
    pend_valid = 1'b0; pend_cnt = 0; pend_id = 1'b0; pend_data = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pend_valid = 1'b0;
      end else begin
        if (pend_valid) pend_cnt++;
        check("rvalid_exclusive", 32'(c_if.rvalid & p_if.rvalid), 32'd0);
        check("gnt_exclusive", 32'(c_if.gnt & p_if.gnt), 32'd0);
        if (c_if.rvalid || p_if.rvalid) begin
          check("rvalid_expected", 32'(pend_valid), 32'd1);
          if (pend_valid) begin
            check("rvalid_latency", 32'(pend_cnt), 32'(RD_LAT));
            check("rvalid_id", 32'(p_if.rvalid), 32'(pend_id));
            check("rdata", p_if.rvalid ? p_if.rdata : c_if.rdata, pend_data);
          end
          pend_valid = 1'b0;
        end else if (pend_valid && pend_cnt >= RD_LAT) begin
          fail_event("rvalid_missing");
          pend_valid = 1'b0;
        end
        if (c_if.gnt || p_if.gnt) begin
          check("gnt_while_read_pending", 32'(pend_valid), 32'd0);
          if (exp_q.size() == 0) begin
            fail_event("gnt_unexpected");
          end else begin
            e = exp_q.pop_front();
            check("gnt_id", 32'(p_if.gnt), 32'(e.id));
            check("ram_wen", 32'(ram_wen), 32'(e.we));
            check("ram_rden", 32'(ram_rden), 32'(!e.we));
            check("ram_addr", 32'(ram_addr), 32'(e.addr));
            check("ram_byteena", 32'(ram_byteena), e.we ? 32'(e.mask) : 32'hF);
            if (e.we) begin
              check("ram_wdata", ram_wdata, e.wdata);
            end else begin
              pend_valid = 1'b1; pend_cnt = 0; pend_id = e.id; pend_data = e.rdata;
            end
          end
        end else begin
          check("strobe_without_gnt", 32'(ram_wen | ram_rden), 32'd0);
        end
      end
      if (!reset && ram_wen) ram_mem[ram_addr] = merge_bytes(ram_mem[ram_addr], ram_wdata, ram_byteena);
      if (!reset && ram_rden) begin
        rd_data = ram_mem[ram_addr];
        rd_left = RD_LAT;
      end
      // Data is only valid in the single cycle the RAM promises it.
      ram_rdata = (rd_left == 1) ? rd_data : $urandom();
      if (rd_left > 0) rd_left--;
    end
  end

  task automatic set_req(input logic id, input xact_t t);
    if (id) begin
      p_if.req = 1'b1; p_if.we = t.we; p_if.addr = t.addr; p_if.wdata = t.wdata; p_if.wmask = t.mask;
    end else begin
      c_if.req = 1'b1; c_if.we = t.we; c_if.addr = t.addr; c_if.wdata = t.wdata; c_if.wmask = t.mask;
    end
  endtask

  task automatic drop_req(input logic id);
    if (id) p_if.req = 1'b0;
    else    c_if.req = 1'b0;
  endtask

  task automatic run_req(input logic id);
    xact_t t;
    int    waitc;
    bit    got;
    bit    first;
    first = 1'b1;
    while ((id ? pq.size() : cq.size()) > 0) begin
      if (id) t = pq.pop_front();
      else    t = cq.pop_front();
      set_req(id, t);
      waitc = 0; got = 1'b0;
      while (!got && waitc < 64) begin
        @(negedge clk);
        waitc++;
        got = id ? p_if.gnt : c_if.gnt;
      end
      if (!got) fail_event(id ? "p_gnt_timeout" : "c_gnt_timeout");
      else if (first && id == first_win) check("first_gnt_latency", 32'(waitc), 32'd1);
      first = 1'b0;
    end
    drop_req(id);
  endtask

  // Reference: both queues stay requesting until drained, so the grant order is a queue merge.
  task automatic predict();
    xact_t qc[$];
    xact_t qp[$];
    xact_t t;
    logic  win;
    bit    firstpick;
    qc = cq; qp = pq; firstpick = 1'b1;
    while (qc.size() > 0 || qp.size() > 0) begin
      if (qc.size() > 0 && qp.size() > 0) begin
`ifdef RAM_ARB_RR_EN
        win = (model_ptr == 1'b1) ? 1'b0 : 1'b1;
`else
        win = 1'b0;
`endif
      end else begin
        win = (qp.size() > 0);
      end
      if (win) t = qp.pop_front();
      else     t = qc.pop_front();
      t.id = win;
      if (firstpick) first_win = win;
      firstpick = 1'b0;
      model_ptr = win;
      if (t.we) ref_mem[t.addr] = merge_bytes(ref_mem[t.addr], t.wdata, t.mask);
      else      t.rdata = ref_mem[t.addr];
      exp_q.push_back(t);
    end
  endtask

  task automatic run_batch();
    int guard;
    predict();
    fork
      run_req(1'b0);
      run_req(1'b1);
    join
    guard = 0;
    while ((exp_q.size() > 0 || pend_valid) && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() > 0 || pend_valid) begin
      fail_event("drain_timeout");
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_c_gnt"}, 32'(c_if.gnt), 32'd0);
    check({tag, "_p_gnt"}, 32'(p_if.gnt), 32'd0);
    check({tag, "_rvalid"}, 32'(c_if.rvalid | p_if.rvalid), 32'd0);
    check({tag, "_strobes"}, 32'(ram_wen | ram_rden), 32'd0);
    check({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    check({tag, "_ram_wdata"}, ram_wdata, 32'd0);
    check({tag, "_ram_byteena"}, 32'(ram_byteena), 32'd0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int nc;
    int np;
    logic [AW-1:0] a;
    reset = 1'b1;
    c_if.req = 1'b0; c_if.we = 1'b0; c_if.addr = '0; c_if.wdata = '0; c_if.wmask = '0;
    p_if.req = 1'b0; p_if.we = 1'b0; p_if.addr = '0; p_if.wdata = '0; p_if.wmask = '0;
    for (int i = 0; i < 1024; i++) begin
      ram_mem[i] = 32'(i) * 32'h9E3779B1;
      ref_mem[i] = ram_mem[i];
    end
    model_ptr = 1'b1;
    first_win = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);

    cq.push_back(mk(1'b1, 10'h010, 32'hDEADBEEF, 4'hF));
    cq.push_back(mk(1'b0, 10'h010, 32'h0, 4'h0));
    run_batch();

    cq.push_back(mk(1'b1, 10'h010, 32'h00AB0000, 4'b0100));
    cq.push_back(mk(1'b0, 10'h010, 32'h0, 4'h0));
    run_batch();

    for (int i = 0; i < 4; i++) begin
      cq.push_back(mk(1'b1, 10'(32'h020 + i), $urandom(), 4'hF));
      pq.push_back(mk(1'b1, 10'(32'h030 + i), $urandom(), 4'hF));
    end
    run_batch();
    for (int i = 0; i < 4; i++) begin
      cq.push_back(mk(1'b0, 10'(32'h020 + i), 32'h0, 4'h0));
      pq.push_back(mk(1'b0, 10'(32'h030 + i), 32'h0, 4'h0));
    end
    run_batch();

    cq.push_back(mk(1'b0, 10'h010, 32'h0, 4'h0));
    pq.push_back(mk(1'b1, 10'h040, 32'h12345678, 4'hF));
    run_batch();

    pq.push_back(mk(1'b1, 10'h3FF, 32'hCAFEF00D, 4'hF));
    cq.push_back(mk(1'b0, 10'h3FF, 32'h0, 4'h0));
    run_batch();

    // Reset one cycle after a read issues: no rvalid may follow.
    cq.push_back(mk(1'b0, 10'h010, 32'h0, 4'h0));
    predict();
    run_req(1'b0);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check_outputs_zero("midreset");
    @(posedge clk); #1 reset = 1'b0;
    model_ptr = 1'b1;
    repeat (RD_LAT + 4) @(negedge clk);
    cq.push_back(mk(1'b0, 10'h010, 32'h0, 4'h0));
    run_batch();

    repeat (40) begin
      nc = $urandom_range(0, 4);
      np = $urandom_range(0, 4);
      for (int i = 0; i < nc; i++) begin
        a = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom_range(0, 15));
        cq.push_back(mk(1'($urandom_range(0, 1)), a, $urandom(), 4'($urandom_range(0, 15))));
      end
      for (int i = 0; i < np; i++) begin
        a = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom_range(0, 15));
        pq.push_back(mk(1'($urandom_range(0, 1)), a, $urandom(), 4'($urandom_range(0, 15))));
      end
      run_batch();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
